// File: rtl/gs_stream_engine_pkg.sv
// Shared constants and types for the grayscale stream engine:
// luma coefficients, rounding constant, FSM state encodings and pixel layout.
package gs_stream_engine_pkg;

    localparam int unsigned GS_CR  = 77;
    localparam int unsigned GS_CG  = 150;
    localparam int unsigned GS_CB  = 29;
    localparam int unsigned GS_RND = 128;

    localparam int unsigned PIX_W  = 24;
    localparam int unsigned LUMA_W = 8;
    localparam int unsigned SUM_W  = 17;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } gs_state_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

endpackage

// File: rtl/gs_stream_engine_if.sv
// Frame-buffer read port and gray-buffer write port of the grayscale engine.
interface gs_stream_engine_if #(
    parameter int unsigned ADDR_W = 15
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [23:0]       rd_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data,
        input  rd_data
    );

    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
        output rd_data
    );
endinterface

// File: rtl/gs_luma.sv
// RGB888 to 8-bit luma, one register stage, valid passed alongside.
// Build option: GS_ROUND_EN selects round-to-nearest instead of truncation.
module gs_luma
    import gs_stream_engine_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vld_in,
    input  rgb_t              pix,
    output logic              vld_out,
    output logic [LUMA_W-1:0] luma
);

`ifdef GS_ROUND_EN
    localparam bit ROUND_EN = 1'b1;
`else
    localparam bit ROUND_EN = 1'b0;
`endif

    logic [SUM_W-1:0] sum_c;
    logic [SUM_W-1:0] sum_adj_c;
    logic             unused_sum_bits;

    // Weighted sum; max 65280 (+128 when rounding) so 17 bits never overflow
    assign sum_c = SUM_W'(GS_CR) * SUM_W'(pix.r)
                 + SUM_W'(GS_CG) * SUM_W'(pix.g)
                 + SUM_W'(GS_CB) * SUM_W'(pix.b);

    assign sum_adj_c = sum_c + (ROUND_EN ? SUM_W'(GS_RND) : SUM_W'(0));

    assign unused_sum_bits = ^{sum_adj_c[16], sum_adj_c[7:0]};

    // Output register: luma = bits [15:8] of the (optionally rounded) sum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_out <= 1'b0;
            luma    <= '0;
        end else begin
            vld_out <= vld_in;
            if (vld_in) begin
                luma <= sum_adj_c[15:8];
            end
        end
    end

endmodule

// File: rtl/gs_stream_engine.sv
// Grayscale stream engine: reads NUM_PIX RGB888 pixels from the frame buffer,
// converts each to luma (two-cycle read-to-write latency, one pixel per clock)
// and writes them to a contiguous gray region; GS_done is a level handshake.
// Build option: GS_ROUND_EN (round-to-nearest luma, handled in gs_luma).
module gs_stream_engine
    import gs_stream_engine_pkg::*;
#(
    parameter int unsigned NUM_PIX  = 16384,
    parameter int unsigned ADDR_W   = 15,
    parameter int unsigned IN_BASE  = 0,
    parameter int unsigned OUT_BASE = 16384
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               GS_enable,
    output logic               GS_done,
    gs_stream_engine_if.master bus
);

    localparam int unsigned CNT_W = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;

    gs_state_e         state_q, state_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0] wr_idx_q, wr_idx_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              rd_en_q, rd_en_d;
    logic              rd_vld_q, rd_vld_d;
    logic              done_q, done_d;

    logic              abort_c;
    logic              last_rd_c;
    logic              luma_vld_c;
    logic              luma_vld_q;
    logic [LUMA_W-1:0] luma_q;
    rgb_t              pix_c;

    assign abort_c   = !GS_enable && ((state_q == ST_RUN) || (state_q == ST_DRAIN));
    assign last_rd_c = (rd_cnt_q == CNT_W'(NUM_PIX - 1));
    assign pix_c     = rgb_t'(bus.rd_data);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rd_cnt_q  <= '0;
            rd_addr_q <= ADDR_W'(IN_BASE);
            wr_idx_q  <= '0;
            wr_addr_q <= ADDR_W'(OUT_BASE);
            rd_en_q   <= 1'b0;
            rd_vld_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_cnt_q  <= rd_cnt_d;
            rd_addr_q <= rd_addr_d;
            wr_idx_q  <= wr_idx_d;
            wr_addr_q <= wr_addr_d;
            rd_en_q   <= rd_en_d;
            rd_vld_q  <= rd_vld_d;
            done_q    <= done_d;
        end
    end

    // Next state; a low GS_enable aborts RUN/DRAIN and releases DONE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (GS_enable) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!GS_enable)     state_d = ST_IDLE;
                else if (last_rd_c) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // last write is on the bus once no read data is outstanding
                if (!GS_enable)     state_d = ST_IDLE;
                else if (!rd_vld_q) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (!GS_enable) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs, counters and valid alignment
    always_comb begin
        rd_en_d    = 1'b0;
        rd_addr_d  = rd_addr_q;
        rd_cnt_d   = rd_cnt_q;
        wr_idx_d   = wr_idx_q;
        wr_addr_d  = wr_addr_q;
        rd_vld_d   = rd_en_q && !abort_c;
        luma_vld_c = rd_vld_q && !abort_c;
        done_d     = (state_d == ST_DONE);

        if (luma_vld_c) begin
            wr_addr_d = ADDR_W'(OUT_BASE) + wr_idx_q;
            wr_idx_d  = wr_idx_q + ADDR_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (GS_enable) begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = ADDR_W'(IN_BASE);
                    rd_cnt_d  = '0;
                    wr_idx_d  = '0;
                end
            end
            ST_RUN: begin
                if (GS_enable && !last_rd_c) begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = rd_addr_q + ADDR_W'(1);
                    rd_cnt_d  = rd_cnt_q + CNT_W'(1);
                end
            end
            default: begin
            end
        endcase
    end

    // Luma conversion aligned with the returning read data
    gs_luma u_luma (
        .clk     (clk),
        .rst_n   (rst_n),
        .vld_in  (luma_vld_c),
        .pix     (pix_c),
        .vld_out (luma_vld_q),
        .luma    (luma_q)
    );

    assign bus.rd_en   = rd_en_q;
    assign bus.rd_addr = rd_addr_q;
    assign bus.wr_en   = luma_vld_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = luma_q;
    assign GS_done     = done_q;

endmodule

// File: tb/tb_gs_stream_engine.sv
// Scoreboard bench for gs_stream_engine: a 16-pixel instance (input region
// wrapping the address space) and a 1-pixel instance share one frame memory.
module tb_gs_stream_engine;

    localparam int unsigned AW = 15;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n;
    logic en_a, en_b;
    logic done_a, done_b;

    gs_stream_engine_if #(.ADDR_W(AW)) bus_a ();
    gs_stream_engine_if #(.ADDR_W(AW)) bus_b ();

    gs_stream_engine #(.NUM_PIX(16), .ADDR_W(AW), .IN_BASE(32760), .OUT_BASE(16384)) u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .GS_enable (en_a),
        .GS_done   (done_a),
        .bus       (bus_a)
    );

    gs_stream_engine #(.NUM_PIX(1), .ADDR_W(AW), .IN_BASE(1000), .OUT_BASE(300)) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .GS_enable (en_b),
        .GS_done   (done_b),
        .bus       (bus_b)
    );

    always #5 clk = ~clk;

    int          n_run = 0;
    int          n_fail = 0;
    logic [23:0] mem [0:32767];
    logic [23:0] frame [16];
    logic [23:0] pat [4] = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFFFF};
    wr_t         sb_a [$];
    wr_t         sb_b [$];
    wr_t         mon_w;
    int          sel;

    logic          s_rd_en, s_wr_en, s_done;
    logic [AW-1:0] s_rd_addr, s_wr_addr;
    logic [7:0]    s_wr_data;

    always_comb begin
        if (sel == 1) begin
            s_rd_en = bus_b.rd_en; s_rd_addr = bus_b.rd_addr; s_wr_en = bus_b.wr_en;
            s_wr_addr = bus_b.wr_addr; s_wr_data = bus_b.wr_data; s_done = done_b;
        end else begin
            s_rd_en = bus_a.rd_en; s_rd_addr = bus_a.rd_addr; s_wr_en = bus_a.wr_en;
            s_wr_addr = bus_a.wr_addr; s_wr_data = bus_a.wr_data; s_done = done_a;
        end
    end

    // Frame buffer: data for a read appears one cycle later, noise otherwise
    always @(posedge clk) bus_a.rd_data <= bus_a.rd_en ? mem[bus_a.rd_addr] : 24'($urandom);
    always @(posedge clk) bus_b.rd_data <= bus_b.rd_en ? mem[bus_b.rd_addr] : 24'($urandom);

    function automatic void check(string name, int act, int exp);
        n_run++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // Reference luma: 77R+150G+29B, optionally +128, divided by 256
    function automatic logic [7:0] ref_luma(logic [23:0] p);
        int unsigned s;
        s = 32'd77 * 32'(p[23:16]) + 32'd150 * 32'(p[15:8]) + 32'd29 * 32'(p[7:0]);
`ifdef GS_ROUND_EN
        s = s + 32'd128;
`endif
        return 8'(s / 32'd256);
    endfunction

    function automatic int npix();    return (sel == 1) ? 1 : 16;        endfunction
    function automatic int in_base(); return (sel == 1) ? 1000 : 32760;  endfunction
    function automatic int out_base();return (sel == 1) ? 300 : 16384;   endfunction

    // Write monitor: every write must match the oldest expected one
    always @(negedge clk) begin
        if (bus_a.wr_en) begin
            check("a_sb_nonempty", int'(sb_a.size() != 0), 1);
            if (sb_a.size() != 0) begin
                mon_w = sb_a.pop_front();
                check("a_wr_addr", int'(bus_a.wr_addr), int'(mon_w.addr));
                check("a_wr_data", int'(bus_a.wr_data), int'(mon_w.data));
            end
        end
        if (bus_b.wr_en) begin
            check("b_sb_nonempty", int'(sb_b.size() != 0), 1);
            if (sb_b.size() != 0) begin
                mon_w = sb_b.pop_front();
                check("b_wr_addr", int'(bus_b.wr_addr), int'(mon_w.addr));
                check("b_wr_data", int'(bus_b.wr_data), int'(mon_w.data));
            end
        end
    end

    task automatic set_en(input logic v);
        if (sel == 1) en_b = v; else en_a = v;
    endtask

    task automatic load_frame(input bit fixed);
        for (int k = 0; k < npix(); k++) begin
            if (fixed && k < 4) frame[k] = pat[k];
            else                frame[k] = 24'($urandom);
            mem[AW'(in_base() + k)] = frame[k];
        end
    endtask

    task automatic push_exp(input int cnt);
        wr_t w;
        for (int k = 0; k < cnt; k++) begin
            w.addr = AW'(out_base() + k);
            w.data = ref_luma(frame[k]);
            if (sel == 1) sb_b.push_back(w); else sb_a.push_back(w);
        end
    endtask

    task automatic check_rst(input string tag);
        check({tag, "_rd_en"},   int'(s_rd_en), 0);
        check({tag, "_rd_addr"}, int'(s_rd_addr), in_base() % 32768);
        check({tag, "_wr_en"},   int'(s_wr_en), 0);
        check({tag, "_wr_addr"}, int'(s_wr_addr), out_base());
        check({tag, "_wr_data"}, int'(s_wr_data), 0);
        check({tag, "_done"},    int'(s_done), 0);
    endtask

    // Full frame from enable to done, then the done handshake
    task automatic run_full(input string tag);
        int n, rd_n, wr_n, first_rd, last_rd, first_wr, last_wr, done_cyc, hd_lo, h_rd, h_wr;
        n = npix();
        rd_n = 0; wr_n = 0; first_rd = -1; last_rd = -1; first_wr = -1; last_wr = -1; done_cyc = -1;
        push_exp(n);
        @(negedge clk);
        set_en(1'b1);
        for (int c = 0; c < n + 40 && done_cyc < 0; c++) begin
            @(negedge clk);
            if (s_rd_en) begin
                if (first_rd < 0) begin
                    first_rd = c;
                    check({tag, "_first_rd_addr"}, int'(s_rd_addr), in_base() % 32768);
                end
                last_rd = c; rd_n++;
            end
            if (s_wr_en) begin
                if (first_wr < 0) first_wr = c;
                last_wr = c; wr_n++;
            end
            if (s_done) done_cyc = c;
        end
        check({tag, "_done_cyc"}, done_cyc, n + 2);
        check({tag, "_first_rd"}, first_rd, 0);
        check({tag, "_last_rd"},  last_rd, n - 1);
        check({tag, "_rd_count"}, rd_n, n);
        check({tag, "_first_wr"}, first_wr, 2);
        check({tag, "_last_wr"},  last_wr, n + 1);
        check({tag, "_wr_count"}, wr_n, n);
        check({tag, "_sb_empty"}, (sel == 1) ? sb_b.size() : sb_a.size(), 0);
        hd_lo = 0; h_rd = 0; h_wr = 0;
        repeat (10) begin
            @(negedge clk);
            if (!s_done) hd_lo++;
            if (s_rd_en) h_rd++;
            if (s_wr_en) h_wr++;
        end
        check({tag, "_hold_done_low"}, hd_lo, 0);
        check({tag, "_hold_reads"},    h_rd, 0);
        check({tag, "_hold_writes"},   h_wr, 0);
        set_en(1'b0);
        @(negedge clk);
        check({tag, "_done_drop"}, int'(s_done), 0);
        @(negedge clk);
    endtask

    // Abort after five reads: only the three completed writes may appear
    task automatic run_abort();
        int rd_n, d_hi, w_n;
        rd_n = 0; d_hi = 0; w_n = 0;
        load_frame(1'b0);
        push_exp(3);
        @(negedge clk);
        set_en(1'b1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (s_rd_en) rd_n++;
            if (c == 4) set_en(1'b0);
        end
        @(negedge clk);
        check("abort_rd_en", int'(s_rd_en), 0);
        check("abort_wr_en", int'(s_wr_en), 0);
        check("abort_reads", rd_n, 5);
        repeat (20) begin
            @(negedge clk);
            if (s_done) d_hi++;
            if (s_wr_en) w_n++;
        end
        check("abort_no_done", d_hi, 0);
        check("abort_no_writes", w_n, 0);
        check("abort_sb_empty", sb_a.size(), 0);
    endtask

    initial begin
        rst_n = 1'b0; en_a = 1'b0; en_b = 1'b0; sel = 0;
        repeat (3) @(negedge clk);
        check_rst("rst_a");
        sel = 1; #1;
        check_rst("rst_b");
        sel = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        load_frame(1'b1);
        run_full("fixed");
        for (int i = 0; i < 3; i++) begin
            load_frame(1'b0);
            run_full($sformatf("rand%0d", i));
        end

        run_abort();
        load_frame(1'b0);
        run_full("restart");

        // Asynchronous reset in the middle of a frame
        load_frame(1'b0);
        push_exp(16);
        @(negedge clk);
        set_en(1'b1);
        repeat (7) @(negedge clk);
        #2;
        rst_n = 1'b0;
        en_a  = 1'b0;
        #1;
        check_rst("midrun_rst");
        sb_a.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        load_frame(1'b0);
        run_full("post_rst");

        sel = 1;
        for (int i = 0; i < 3; i++) begin
            load_frame(i == 0);
            run_full($sformatf("one%0d", i));
        end
        sel = 0;
        check("end_sb_a_empty", sb_a.size(), 0);
        check("end_sb_b_empty", sb_b.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
